// File: rtl/t_toggle_counter_pkg.sv
// ============================================================================
// Module : t_cnt_pkg
// Brief  : Shared defaults and effective-modulus helper for t_toggle_counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package t_cnt_pkg;

  localparam int unsigned c_width_default   = 4;
  localparam int unsigned c_modulus_default = 10;

  // MODULUS of 0 selects the full 2**WIDTH range.
  function automatic int unsigned mod_of(input int unsigned width, input int unsigned modulus);
    return (modulus == 0) ? (32'd1 << width) : modulus;
  endfunction

endpackage

`default_nettype wire

// File: rtl/t_toggle_counter_if.sv
// ============================================================================
// Module : t_toggle_counter_if
// Brief  : Control/status bundle of the toggle counter (master drives controls).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface t_toggle_counter_if
  import t_cnt_pkg::*;
#(
  parameter int WIDTH = c_width_default
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_bar;
  logic [WIDTH-1:0] t_vec;
  logic             tc;

  modport master (
    output en, up, load, load_val,
    input  count, count_bar, t_vec, tc
  );

  modport slave (
    input  en, up, load, load_val,
    output count, count_bar, t_vec, tc
  );

endinterface

`default_nettype wire

// File: rtl/t_toggle_counter_stage.sv
// ============================================================================
// Module : t_stage
// Brief  : Single T flip-flop cell with synchronous active-high reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module t_stage (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q,
  output logic q_bar
);

  logic q_q;
  logic q_d;

  assign q_d = t ? ~q_q : q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

`default_nettype wire

// File: rtl/t_toggle_counter.sv
// ============================================================================
// Module : t_toggle_counter
// Brief  : Modulo-N up/down counter driving a row of T stages with per-bit
//          toggle enables. Optional parallel load under macro T_CNT_LOAD_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module t_toggle_counter
  import t_cnt_pkg::*;
#(
  parameter int WIDTH   = c_width_default,
  parameter int MODULUS = c_modulus_default
) (
  input  logic                clk,
  input  logic                reset,
  t_toggle_counter_if.slave   bus
);

  localparam int unsigned      c_mod = mod_of(WIDTH, MODULUS);
  localparam logic [WIDTH-1:0] c_max = WIDTH'(c_mod - 1);
  localparam logic [WIDTH:0]   c_mod_ext = (WIDTH+1)'(c_mod);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_bar_w;
  logic [WIDTH-1:0] next_d;
  logic [WIDTH-1:0] t_vec_d;
  logic             tc_d;
  logic             load_act;

`ifdef T_CNT_LOAD_EN
  assign load_act = bus.load;
`else
  logic unused_load;
  assign load_act    = 1'b0;
  assign unused_load = bus.load;
`endif

  always_comb begin
    next_d  = count_q;
    t_vec_d = '0;
    tc_d    = bus.up ? (count_q == c_max) : (count_q == '0);
    if (load_act) begin
      // Out-of-range load values fold to zero so the count never leaves 0..MOD-1.
      next_d  = ({1'b0, bus.load_val} >= c_mod_ext) ? '0 : bus.load_val;
      t_vec_d = count_q ^ next_d;
    end else begin
      if (bus.up) begin
        next_d = (count_q == c_max) ? '0 : count_q + WIDTH'(1);
      end else begin
        next_d = (count_q == '0) ? c_max : count_q - WIDTH'(1);
      end
      t_vec_d = bus.en ? (count_q ^ next_d) : '0;
      tc_d    = bus.en & tc_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    t_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .t     (t_vec_d[i]),
      .q     (count_q[i]),
      .q_bar (count_bar_w[i])
    );
  end

  assign bus.count     = count_q;
  assign bus.count_bar = count_bar_w;
  assign bus.t_vec     = t_vec_d;
  assign bus.tc        = tc_d;

endmodule

`default_nettype wire

// File: tb/tb_t_toggle_counter.sv
// ============================================================================
// Module : tb_t_toggle_counter
// Brief  : Scoreboard bench for t_toggle_counter (MODULUS 10 and full range).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_t_toggle_counter;

  localparam int W = 4;

  typedef struct packed {
    bit              comb;
    logic [1:0][3:0] cnt;
    logic [1:0][3:0] tv;
    logic [1:0]      tc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cnt [2] = '{0, 0};
  int   modv[2] = '{10, 16};
  bit   primed  = 1'b0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  t_toggle_counter_if #(.WIDTH(W)) bus_a ();
  t_toggle_counter_if #(.WIDTH(W)) bus_b ();

  t_toggle_counter #(.WIDTH(W), .MODULUS(10)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  t_toggle_counter #(.WIDTH(W), .MODULUS(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: counts as plain integers modulo MOD, toggles are old ^ new.
  task automatic issue(input bit r, input bit e, input bit u, input bit l, input logic [3:0] lv);
    exp_t x;
    int   nxt;
    int   tv;
    bit   tcv;
    @(negedge clk);
    reset = r;
    bus_a.en = e; bus_a.up = u; bus_a.load = l; bus_a.load_val = lv;
    bus_b.en = e; bus_b.up = u; bus_b.load = l; bus_b.load_val = lv;
    x = '0;
    x.comb = primed;
    primed = 1'b1;
    for (int k = 0; k < 2; k++) begin
      nxt = u ? (cnt[k] + 1) % modv[k] : (cnt[k] + modv[k] - 1) % modv[k];
      tcv = e && (u ? (cnt[k] == modv[k] - 1) : (cnt[k] == 0));
      tv  = e ? (cnt[k] ^ nxt) : 0;
      if (!e) nxt = cnt[k];
`ifdef T_CNT_LOAD_EN
      if (l) begin
        nxt = (int'(lv) >= modv[k]) ? 0 : int'(lv);
        tv  = cnt[k] ^ nxt;
        tcv = u ? (cnt[k] == modv[k] - 1) : (cnt[k] == 0);
      end
`endif
      if (r) nxt = 0;
      x.tv[k]  = 4'(tv);
      x.tc[k]  = tcv;
      x.cnt[k] = 4'(nxt);
      cnt[k]   = nxt;
    end
    sbq.push_back(x);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] inv;
    forever begin
      @(negedge clk);
      #3;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        if (e.comb) begin
          chk("a_t_vec", int'(bus_a.t_vec), int'(e.tv[0]));
          chk("a_tc",    int'(bus_a.tc),    int'(e.tc[0]));
          chk("b_t_vec", int'(bus_b.t_vec), int'(e.tv[1]));
          chk("b_tc",    int'(bus_b.tc),    int'(e.tc[1]));
        end
        @(posedge clk);
        #1;
        chk("a_count", int'(bus_a.count), int'(e.cnt[0]));
        inv = ~e.cnt[0];
        chk("a_count_bar", int'(bus_a.count_bar), int'(inv));
        chk("b_count", int'(bus_b.count), int'(e.cnt[1]));
        inv = ~e.cnt[1];
        chk("b_count_bar", int'(bus_b.count_bar), int'(inv));
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    bus_a.en = 1'b0; bus_a.up = 1'b1; bus_a.load = 1'b0; bus_a.load_val = '0;
    bus_b.en = 1'b0; bus_b.up = 1'b1; bus_b.load = 1'b0; bus_b.load_val = '0;

    repeat (2) issue(1, 1, 1, 0, 4'd0);
    repeat (12) issue(0, 1, 1, 0, 4'd0);
    issue(1, 1, 1, 0, 4'd0);
    repeat (3) issue(0, 1, 0, 0, 4'd0);
    issue(1, 0, 1, 0, 4'd0);
    repeat (3) issue(0, 1, 1, 0, 4'd0);
    issue(0, 1, 1, 0, 4'd0);
    issue(0, 0, 1, 0, 4'd0);
    issue(0, 1, 1, 0, 4'd0);
    repeat (2) issue(0, 1, 1, 0, 4'd0);
    issue(1, 1, 1, 0, 4'd0);
    repeat (2) issue(0, 1, 1, 0, 4'd0);
    issue(0, 1, 1, 1, 4'd6);
    issue(0, 1, 1, 1, 4'd12);
    issue(0, 1, 1, 0, 4'd0);
    issue(1, 1, 1, 1, 4'd5);
    issue(0, 1, 0, 0, 4'd0);

    repeat (400) begin
      issue($urandom_range(0, 31) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0,
            4'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
